// File: rtl/fetch_pkg.sv
// Shared constants and the buffered-entry type for the instruction-fetch controller.
package fetch_pkg;

    localparam int               XLEN_DEFAULT       = 32;
    localparam logic [31:0]      RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int               IMEM_WORDS_DEFAULT = 64;
    localparam int               PC_STEP            = 4;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry prefetch buffer of {pc, inst} with push/pop/flush and an occupancy count.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t rd_entry,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // When full, a pop frees the head slot, which is exactly where wr_ptr points.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop & (count_q != 2'd0);
        do_push  = push & ((count_q != 2'd2) | do_pop);

        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_entry = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC sequencing, imem addressing and redirect handling.
// Optional out-of-range fetch stop is enabled with `define FETCH_BOUND_CHECK_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               XLEN       = XLEN_DEFAULT,
    parameter int               IMEM_WORDS = IMEM_WORDS_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [XLEN-1:0] imem_a,
    input  logic [XLEN-1:0] imem_rd,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_fault
);

    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

    if (IMEM_WORDS <= 0 || IMEM_WORDS > (1 << 24)) begin : g_bad_imem_words
        $error("fetch_ctrl: IMEM_WORDS out of supported range");
    end

    logic [XLEN-1:0] pc_q, pc_d;
    logic [1:0]      count;
    logic            pop;
    logic            push;
    logic            has_room;
    fetch_entry_t    wr_entry;
    fetch_entry_t    rd_entry;

    assign pop      = inst_valid & inst_ready;
    assign has_room = (count != 2'd2) | pop;

`ifdef FETCH_BOUND_CHECK_EN
    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * PC_STEP);

    logic fault_q, fault_d;
    logic in_range;

    assign in_range    = pc_q < PC_LIMIT;
    assign push        = !redirect_valid & !fault_q & has_room & in_range;
    assign fetch_fault = fault_q;

    // Fault is sticky; only a redirect (or reset) restarts fetching.
    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) begin
            fault_d = 1'b0;
        end else if (!in_range) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign push        = !redirect_valid & has_room;
    assign fetch_fault = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & WORD_MASK;
        end else if (push) begin
            pc_d = pc_q + XLEN'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign imem_a        = pc_q & WORD_MASK;
    assign wr_entry.pc   = pc_q;
    assign wr_entry.inst = imem_rd;

    // A redirect flushes the buffer, which also discards any same-cycle pop.
    fetch_fifo u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry),
        .count    (count)
    );

    assign inst_valid = (count != 2'd0);
    assign inst       = rd_entry.inst;
    assign inst_pc    = rd_entry.pc;

endmodule
